// File: rtl/seg7_hex_counter.sv
// Free-running hex digit counter driving one 7-segment display, with a
// prescaler on sclk and RGB status LEDs reflecting the reset state.
module seg7_hex_counter #(
  parameter logic [31:0] TICK_COUNT   = 32'h400000,
  parameter bit          COMMON_ANODE = 1'b1
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       en,
  output logic [6:0] seg,
  output logic [3:0] digit,
  output logic       tick,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b
);

  logic [31:0] prescaler_q, prescaler_d;
  logic [3:0]  digit_q, digit_d;
  logic        tick_q, tick_d;
  logic [6:0]  pattern;

  always_comb begin
    prescaler_d = prescaler_q;
    digit_d     = digit_q;
    tick_d      = 1'b0;
    if (en) begin
      if (prescaler_q == TICK_COUNT) begin
        prescaler_d = '0;
        digit_d     = digit_q + 4'd1;
        tick_d      = 1'b1;
      end else begin
        prescaler_d = prescaler_q + 32'd1;
      end
    end
  end

  // Reset wins over a coincident terminal count, so no advance that cycle.
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      digit_q     <= '0;
      tick_q      <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      digit_q     <= digit_d;
      tick_q      <= tick_d;
    end
  end

  // Active-high segment pattern, bit0 = a ... bit6 = g.
  always_comb begin
    pattern = '0;
    unique case (digit_q)
      4'h0: pattern = 7'h3F;
      4'h1: pattern = 7'h06;
      4'h2: pattern = 7'h5B;
      4'h3: pattern = 7'h4F;
      4'h4: pattern = 7'h66;
      4'h5: pattern = 7'h6D;
      4'h6: pattern = 7'h7D;
      4'h7: pattern = 7'h07;
      4'h8: pattern = 7'h7F;
      4'h9: pattern = 7'h6F;
      4'hA: pattern = 7'h77;
      4'hB: pattern = 7'h7C;
      4'hC: pattern = 7'h39;
      4'hD: pattern = 7'h5E;
      4'hE: pattern = 7'h79;
      4'hF: pattern = 7'h71;
    endcase
  end

  assign seg   = COMMON_ANODE ? ~pattern : pattern;
  assign digit = digit_q;
  assign tick  = tick_q;

  // Active-low RGB: green while running, red while held in reset.
  assign led_r = rst_n;
  assign led_g = ~rst_n;
  assign led_b = 1'b1;

endmodule

// File: tb/tb_seg7_hex_counter.sv
// Scoreboard bench: two counters (TICK_COUNT=3 common-anode, TICK_COUNT=0
// common-cathode) share stimulus; a behavioural model predicts each cycle.
module tb_seg7_hex_counter;

  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [6:0] seg_a, seg_b;
  logic [3:0] digit_a, digit_b;
  logic       tick_a, tick_b;
  logic       led_r_a, led_g_a, led_b_a;
  logic       led_r_b, led_g_b, led_b_b;

  int checks = 0;
  int errors = 0;

  always #5 sclk = ~sclk;

  seg7_hex_counter #(.TICK_COUNT(32'd3), .COMMON_ANODE(1'b1)) dut_a (
    .sclk(sclk), .rst_n(rst_n), .en(en), .seg(seg_a), .digit(digit_a),
    .tick(tick_a), .led_r(led_r_a), .led_g(led_g_a), .led_b(led_b_a)
  );

  seg7_hex_counter #(.TICK_COUNT(32'd0), .COMMON_ANODE(1'b0)) dut_b (
    .sclk(sclk), .rst_n(rst_n), .en(en), .seg(seg_b), .digit(digit_b),
    .tick(tick_b), .led_r(led_r_b), .led_g(led_g_b), .led_b(led_b_b)
  );

  typedef struct {
    logic [3:0] dig_a;
    logic [6:0] seg_a;
    logic       tick_a;
    logic [3:0] dig_b;
    logic [6:0] seg_b;
    logic       tick_b;
    logic [2:0] leds;
  } exp_t;

  exp_t sb[$];

  logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [31:0] ma_pre = '0;
  logic [3:0]  ma_dig = '0;
  logic        ma_tick = 1'b0;
  logic [3:0]  mb_dig = '0;
  logic        mb_tick = 1'b0;
  int          tick_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e);
    exp_t x;
    rst_n = r;
    en    = e;
    if (!r) begin
      ma_pre = '0; ma_dig = '0; ma_tick = 1'b0;
      mb_dig = '0; mb_tick = 1'b0;
    end else if (e) begin
      if (ma_pre == 32'd3) begin
        ma_pre = '0; ma_dig = ma_dig + 4'd1; ma_tick = 1'b1;
      end else begin
        ma_pre = ma_pre + 32'd1; ma_tick = 1'b0;
      end
      mb_dig = mb_dig + 4'd1; mb_tick = 1'b1;
    end else begin
      ma_tick = 1'b0; mb_tick = 1'b0;
    end
    x.dig_a  = ma_dig;
    x.seg_a  = ~pat[ma_dig];
    x.tick_a = ma_tick;
    x.dig_b  = mb_dig;
    x.seg_b  = pat[mb_dig];
    x.tick_b = mb_tick;
    x.leds   = r ? 3'b101 : 3'b011;
    sb.push_back(x);
    @(posedge sclk);
    #1;
    x = sb.pop_front();
    check("digit_a", 32'(digit_a), 32'(x.dig_a));
    check("seg_a",   32'(seg_a),   32'(x.seg_a));
    check("tick_a",  32'(tick_a),  32'(x.tick_a));
    check("digit_b", 32'(digit_b), 32'(x.dig_b));
    check("seg_b",   32'(seg_b),   32'(x.seg_b));
    check("tick_b",  32'(tick_b),  32'(x.tick_b));
    check("leds_a",  32'({led_r_a, led_g_a, led_b_a}), 32'(x.leds));
    check("leds_b",  32'({led_r_b, led_g_b, led_b_b}), 32'(x.leds));
    if (tick_a === 1'b1) tick_seen++;
  endtask

  initial begin
    // Reset held for two cycles, then enable: first advance on 4th cycle.
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("reset_seg_a", 32'(seg_a), 32'h40);
    check("reset_seg_b", 32'(seg_b), 32'h3F);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    check("first_digit", 32'(digit_a), 32'd1);
    check("first_seg",   32'(seg_a),   32'h79);
    step(1'b1, 1'b1);
    check("tick_one_cycle", 32'(tick_a), 32'd0);

    // 64 periods: full wrap four times, one tick per period.
    tick_seen = 0;
    for (int i = 0; i < 256; i++) step(1'b1, 1'b1);
    check("tick_count", 32'(tick_seen), 32'd64);

    // Freeze mid-period at prescaler=2, then two enabled cycles remain.
    for (int i = 0; i < 8 && ma_pre != 32'd2; i++) step(1'b1, 1'b1);
    check("reached_pre2", ma_pre, 32'd2);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("resume_tick", 32'(tick_a), 32'd1);

    // Reset coincident with terminal count at digit 7 must not advance.
    for (int i = 0; i < 80 && !(ma_dig == 4'd7 && ma_pre == 32'd3); i++) step(1'b1, 1'b1);
    check("reached_7_tc", 32'({ma_dig, ma_pre[3:0]}), 32'h73);
    step(1'b0, 1'b1);
    check("reset_over_tc", 32'(digit_a), 32'd0);

    // Common-cathode unit with TICK_COUNT=0 advances every enabled cycle.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_hex_counter.md
Name: seg7_hex_counter

Overview:
Free-running hex digit counter that drives a single 7-segment display.
- A prescaler divides the system clock.
- A 4-bit digit register increments once per prescaler period.
- A combinational decoder maps the digit to segments a..g, with polarity selectable for common-anode or common-cathode parts.
- Sits between the on-chip HF oscillator clock (sclk) and the FPGA display and RGB status pins.

Parameters:
TICK_COUNT, 32'h400000, prescaler terminal count; digit period = TICK_COUNT+1 sclk cycles (~0.25 s at 16.7 MHz HFOSC).
COMMON_ANODE, 1, 1 = seg outputs active-low (lit = 0); 0 = active-high.

Ports:
sclk  in  1  system clock (HF oscillator output); all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
en  in  1  count enable; 0 freezes the prescaler and digit.
seg  out  7  segment drive, bit0=a, 1=b, 2=c, 3=d, 4=e, 5=f, 6=g; polarity per COMMON_ANODE.
digit  out  4  current digit value.
tick  out  1  one-cycle pulse, high in the cycle the new digit first appears.
led_r  out  1  RGB status, active-low.
led_g  out  1  RGB status, active-low.
led_b  out  1  RGB status, active-low.

Behaviour:
- Reset: sampled only on a rising sclk edge while rst_n=0. Clears prescaler to 0, digit to 0 and tick to 0. Reset overrides en and a coincident terminal count, so the digit does not advance in that cycle.
- Prescaler: 32-bit register.
  - If en=1 and prescaler != TICK_COUNT: prescaler += 1.
  - If en=1 and prescaler == TICK_COUNT: prescaler <= 0, digit <= digit+1 (mod 16, so 15 -> 0), tick <= 1.
  - Otherwise tick <= 0.
  - en=0: prescaler and digit hold; tick <= 0.
- Digit period is therefore exactly TICK_COUNT+1 enabled cycles. Enabled cycles only are counted; gaps with en=0 do not count.
- Decoder: purely combinational from the digit register, zero latency. Active-high pattern (g..a as hex):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - No undefined codes.
- Output polarity: seg = ~pattern when COMMON_ANODE=1; seg = pattern when COMMON_ANODE=0.
- Reset display: digit 0, so seg = 7'h40 (COMMON_ANODE=1) or 7'h3F (COMMON_ANODE=0).
- Status LEDs (combinational from rst_n):
  - rst_n=1: led_r=1, led_g=0, led_b=1 (green = running).
  - rst_n=0: led_r=0, led_g=1, led_b=1 (red = in reset).
- Outputs are never X after the first reset edge. Behaviour before the first reset edge is unspecified.
- TICK_COUNT=0 is legal: digit advances every enabled cycle and tick stays high continuously while en=1.

Test Plan:
1. TICK_COUNT=3, COMMON_ANODE=1; hold rst_n=0 for 2 cycles, then en=1 -> digit=0, seg=7'h40, tick=0, led_g=1 during reset and led_g=0 after. First increment appears 4 cycles after reset release: digit=1, seg=7'h79, tick high for exactly that 1 cycle.
2. Run 64 periods -> digit steps 0..F and wraps F->0. seg matches ~pattern for every digit (e.g. A -> 7'h08, F -> 7'h0E). Exactly 16 tick pulses per wrap.
3. Drop en=0 for 10 cycles mid-period (prescaler=2) -> digit, prescaler and seg frozen, tick=0. After en=1, the increment occurs after the remaining 2 enabled cycles.
4. Assert rst_n=0 in the same cycle the prescaler equals TICK_COUNT with digit=7 -> next cycle digit=0, tick=0, no increment.
5. COMMON_ANODE=0, TICK_COUNT=0, en=1 -> digit increments every cycle. seg sequence is 3F, 06, 5B, 4F, ... and tick stays high.
